// File: rtl/light_meter_pkg.sv
// Shared types and default sizing for the TSL235R light-to-frequency meter.
package light_meter_pkg;

   typedef enum logic [0:0] {P_IDLE, P_RUN} per_state_e;

   localparam int unsigned GATE_CYCLES_DEF    = 100_000_000;
   localparam int unsigned PERIOD_TIMEOUT_DEF = 100_000_000;
   localparam int unsigned CNT_W_DEF          = 32;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detect.
module pulse_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic edge_pulse
);

   logic sync_q1, sync_q2, prev_q;

   // Clearing to 0 means an input already high at reset release is not an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         prev_q     <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_q1    <= async_in;
         sync_q2    <= sync_q1;
         prev_q     <= sync_q2;
         edge_pulse <= sync_q2 & ~prev_q;
      end
   end

endmodule

// File: rtl/light_freq_meter.sv
// Gated edge counter and edge-to-edge period meter for the TSL235R sensor output.
module light_freq_meter
   import light_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES    = GATE_CYCLES_DEF,
   parameter int unsigned PERIOD_TIMEOUT = PERIOD_TIMEOUT_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tsl235r_in,
   input  logic             enable,
   output logic [CNT_W-1:0] frequency,
   output logic [CNT_W-1:0] period,
   output logic             sample_valid,
   output logic             overflow,
   output logic             no_signal
);

   localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned PER_W  = $clog2(PERIOD_TIMEOUT + 1);
   localparam int unsigned WIDE_W = PER_W + CNT_W;

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_TIMEOUT);

   logic edge_pulse;

   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              win_ovf_q, win_ovf_d;
   logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
   per_state_e        state_q, state_d;
   logic [CNT_W-1:0]  freq_q, freq_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              sv_q, sv_d;
   logic              ovf_q, ovf_d;
   logic              nosig_q, nosig_d;

   logic              lost;
   logic [CNT_W-1:0]  cnt_inc;
   logic [WIDE_W-1:0] per_wide;
   logic [CNT_W-1:0]  per_clip;

   pulse_sync_edge u_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (tsl235r_in),
      .edge_pulse (edge_pulse)
   );

   // An edge arriving while the count is already at full scale is lost.
   assign lost     = edge_pulse && (edge_cnt_q == CNT_MAX);
   assign cnt_inc  = (edge_pulse && !lost) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
   assign per_wide = WIDE_W'(per_cnt_q);
   assign per_clip = (per_wide > WIDE_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(per_cnt_q);

   always_comb begin
      gate_d     = gate_q;
      edge_cnt_d = edge_cnt_q;
      win_ovf_d  = win_ovf_q;
      per_cnt_d  = per_cnt_q;
      state_d    = state_q;
      freq_d     = freq_q;
      period_d   = period_q;
      sv_d       = 1'b0;
      ovf_d      = ovf_q;
      nosig_d    = nosig_q;

      if (!enable) begin
         gate_d     = '0;
         edge_cnt_d = '0;
         win_ovf_d  = 1'b0;
         per_cnt_d  = '0;
         state_d    = P_IDLE;
      end else begin
         // Terminal-cycle edges belong to the window being closed.
         if (gate_q == GATE_LAST) begin
            gate_d     = '0;
            freq_d     = cnt_inc;
            ovf_d      = win_ovf_q | lost;
            sv_d       = 1'b1;
            edge_cnt_d = '0;
            win_ovf_d  = 1'b0;
         end else begin
            gate_d     = gate_q + GATE_W'(1);
            edge_cnt_d = cnt_inc;
            win_ovf_d  = win_ovf_q | lost;
         end

         case (state_q)
            P_IDLE: begin
               if (edge_pulse) begin
                  per_cnt_d = PER_W'(1);
                  state_d   = P_RUN;
               end
            end
            P_RUN: begin
               if (edge_pulse) begin
                  period_d  = per_clip;
                  per_cnt_d = PER_W'(1);
                  nosig_d   = 1'b0;
               end else if (per_cnt_q == PER_LAST) begin
                  period_d  = '0;
                  nosig_d   = 1'b1;
                  per_cnt_d = '0;
                  state_d   = P_IDLE;
               end else begin
                  per_cnt_d = per_cnt_q + PER_W'(1);
               end
            end
            default: state_d = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gate_q     <= '0;
         edge_cnt_q <= '0;
         win_ovf_q  <= 1'b0;
         per_cnt_q  <= '0;
         state_q    <= P_IDLE;
         freq_q     <= '0;
         period_q   <= '0;
         sv_q       <= 1'b0;
         ovf_q      <= 1'b0;
         nosig_q    <= 1'b1;
      end else begin
         gate_q     <= gate_d;
         edge_cnt_q <= edge_cnt_d;
         win_ovf_q  <= win_ovf_d;
         per_cnt_q  <= per_cnt_d;
         state_q    <= state_d;
         freq_q     <= freq_d;
         period_q   <= period_d;
         sv_q       <= sv_d;
         ovf_q      <= ovf_d;
         nosig_q    <= nosig_d;
      end
   end

   assign frequency    = freq_q;
   assign period       = period_q;
   assign sample_valid = sv_q;
   assign overflow     = ovf_q;
   assign no_signal    = nosig_q;

endmodule

// File: doc/light_freq_meter.md
# light_freq_meter

Measures the TSL235R light-to-frequency sensor output for the Nexys 4 light-control design. It sits between the sensor pin on JD and the embedded system's frequency/irradiance input. The block synchronizes the asynchronous pulse train and counts rising edges over a fixed gate window to produce a frequency value. It also measures the edge-to-edge period for resolution at low light, and flags loss of signal.

## Interface
- GATE_CYCLES, 100_000_000: gate window length in clk cycles; 1 s at 100 MHz, so `frequency` reads in Hz.
- PERIOD_TIMEOUT, 100_000_000: clk cycles without a rising edge before `no_signal` asserts.
- CNT_W, 32: width of the edge counter, period counter and outputs.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- tsl235r_in  in  1  raw sensor pulse, asynchronous to clk
- enable  in  1  measurement enable
- frequency  out  CNT_W  rising edges counted in the last completed gate window
- period  out  CNT_W  clk cycles between the last two rising edges; 0 = invalid
- sample_valid  out  1  one-cycle strobe when `frequency` and `overflow` update
- overflow  out  1  edge count saturated in the last window
- no_signal  out  1  no edge for PERIOD_TIMEOUT cycles

## Operation
- Input path: 2-flop synchronizer on `tsl235r_in`, then a registered rising-edge detect that produces `edge`, one pulse per rising edge.
- Gate counter runs 0..GATE_CYCLES-1 and wraps.
- On the terminal cycle (count = GATE_CYCLES-1):
  - `frequency` <= edge_cnt + edge, saturated to 2^CNT_W-1.
  - `overflow` <= saturation occurred in this window.
  - `sample_valid` <= 1 for one cycle.
  - edge_cnt <= 0.
- An edge on the terminal cycle is counted in the closing window, not the next one.
- edge_cnt saturates at 2^CNT_W-1. It never wraps.
- Period FSM has two states:
  - P_IDLE: on `edge`, per_cnt <= 1 and go to P_RUN.
  - P_RUN, on `edge`: `period` <= per_cnt, per_cnt <= 1, `no_signal` <= 0.
  - P_RUN, no edge: per_cnt increments. When per_cnt = PERIOD_TIMEOUT: `period` <= 0, `no_signal` <= 1, go to P_IDLE.
  - The first edge after P_IDLE never updates `period`.
- `enable` = 0:
  - Gate counter, edge_cnt and per_cnt are held at 0, and the FSM is forced to P_IDLE.
  - `frequency`, `period`, `overflow` and `no_signal` hold their values.
  - `sample_valid` = 0.
  - When `enable` returns to 1, a full-length window starts.
- Reset:
  - `frequency`, `period`, `overflow` and `sample_valid` = 0; `no_signal` = 1.
  - All counters are 0 and the FSM is in P_IDLE.
  - Synchronizer flops are cleared to 0, so an input that is high at reset release does not produce an edge.
  - Reset mid-window discards the partial window.

## Timing
- Input latency: a rising `tsl235r_in` sampled high at clk edge k produces `edge` high during cycle k+2. The counters update at edge k+3.
- `sample_valid`, `frequency` and `overflow` update on the same clk edge, the one ending the terminal cycle.
- With `enable` held at 1, `sample_valid` has a period of exactly GATE_CYCLES.
- `period` and `no_signal` update one cycle after the qualifying `edge`, or after the timeout cycle.
- Input pulses shorter than 1 clk cycle are not guaranteed to be seen. The sensor output is below 1 MHz, so this is not a limitation in use.

## Structure
- Package `light_meter_pkg`:
  - period FSM enum {P_IDLE, P_RUN}
  - default constants for GATE_CYCLES, PERIOD_TIMEOUT and CNT_W
- Sub-module `pulse_sync_edge`: 2-flop synchronizer plus rising-edge detect; inputs clk, reset, async_in; output edge.
- Gate/edge counting and the period FSM live in the top module.
- Expected size: about 200 lines.

## Test plan
Benches use GATE_CYCLES=100, PERIOD_TIMEOUT=50 and CNT_W=32 unless noted.
- Square wave, period 10 cycles, `enable`=1 -> `sample_valid` every 100 cycles, `frequency`=10, `overflow`=0, `period`=10, `no_signal`=0.
- Single edge timed so `edge` falls on the terminal cycle -> counted in that window's `frequency`; next window starts at 0.
- CNT_W=4, square wave with period 2 -> `frequency`=15 and `overflow`=1 for every window; no wrap to small values.
- Input stuck low after activity -> 50 cycles after the last edge, `period`=0 and `no_signal`=1. On restart, the first edge leaves `period`=0; the second edge sets `period`=spacing and `no_signal`=0.
- Assert `reset` for 1 cycle at gate count 60 -> all outputs 0, `no_signal`=1. The next `sample_valid` comes exactly 100 cycles after reset deassert.
- Drop `enable` mid-window for 30 cycles with input toggling -> outputs hold, no `sample_valid`. After re-enable, the first `sample_valid` comes 100 cycles later and counts only edges seen after re-enable.
